// File: rtl/sample_uart_tx.sv
// Sample streamer: FIFO-buffered 16-bit words framed as HEADER/MSB/LSB and sent over an 8N1 UART.
// Build option: define SAMPLE_UART_TX_CHECKSUM_EN to append a CHK byte (HEADER ^ MSB ^ LSB) to each frame.
module sample_uart_tx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  sample_in,
  input  logic                         sample_valid,
  output logic                         uart_tx,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       STOP_IDX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HDR,
    S_MSB,
`ifdef SAMPLE_UART_TX_CHECKSUM_EN
    S_LSB,
    S_CHK
`else
    S_LSB
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [15:0]      rd_data;

  assign full      = (fifo_level == FULL_LVL);
  assign not_empty = (fifo_level != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign push      = sample_valid && (!full || pop);
  assign drop      = sample_valid && full && !pop;
  assign rd_data   = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // NOTE: clocked blocks use <= only, so every flop sees the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit engine: start bit, D0..D7, stop bit, each held CLK_DIV cycles
  // ---------------------------------------------------------------------------
  logic             eng_load;
  logic [7:0]       eng_byte;
  logic             eng_active;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shreg;
  logic             eng_done;

  assign eng_done = eng_active && (bit_cnt == '0) && (bit_idx == STOP_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx    <= 1'b1;
      eng_active <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else if (eng_load) begin
      // A load on the done cycle starts the next start bit with no idle gap.
      uart_tx    <= 1'b0;
      shreg      <= {1'b1, eng_byte};
      bit_cnt    <= CNT_MAX;
      bit_idx    <= '0;
      eng_active <= 1'b1;
    end else if (eng_active) begin
      if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - 1'b1;
      end else if (bit_idx == STOP_IDX) begin
        eng_active <= 1'b0;
        uart_tx    <= 1'b1;
      end else begin
        uart_tx <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_idx <= bit_idx + 1'b1;
        bit_cnt <= CNT_MAX;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [15:0] frame;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    eng_load = 1'b0;
    eng_byte = HEADER;
    pop      = 1'b0;
    case (state)
      S_IDLE: pop = not_empty;
      S_LOAD: eng_load = 1'b1;
      S_HDR: begin
        eng_load = eng_done;
        eng_byte = frame[15:8];
      end
      S_MSB: begin
        eng_load = eng_done;
        eng_byte = frame[7:0];
      end
`ifdef SAMPLE_UART_TX_CHECKSUM_EN
      S_LSB: begin
        eng_load = eng_done;
        eng_byte = HEADER ^ frame[15:8] ^ frame[7:0];
      end
      S_CHK: begin
        pop      = eng_done && not_empty;
        eng_load = pop;
      end
`else
      S_LSB: begin
        pop      = eng_done && not_empty;
        eng_load = pop;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      frame <= '0;
    end else begin
      if (pop) frame <= rd_data;
      case (state)
        S_IDLE: if (pop) state <= S_LOAD;
        S_LOAD: state <= S_HDR;
        S_HDR:  if (eng_done) state <= S_MSB;
        S_MSB:  if (eng_done) state <= S_LSB;
`ifdef SAMPLE_UART_TX_CHECKSUM_EN
        S_LSB:  if (eng_done) state <= S_CHK;
        S_CHK:  if (eng_done) state <= pop ? S_HDR : S_IDLE;
`else
        S_LSB:  if (eng_done) state <= pop ? S_HDR : S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE) || not_empty;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench for sample_uart_tx with CLK_DIV=4, FIFO_DEPTH=4; checks serial bytes bit by bit.
module tb_sample_uart_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [7:0]  HEADER     = 8'hA5;
`ifdef SAMPLE_UART_TX_CHECKSUM_EN
  localparam int unsigned FRAME_CYC  = 40 * CLK_DIV;
`else
  localparam int unsigned FRAME_CYC  = 30 * CLK_DIV;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        uart_tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  sample_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .HEADER     (HEADER)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one 10-bit character; skip = cycles of the start bit already elapsed.
  task automatic check_byte(input logic [7:0] b, input int skip);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int c = skip; c < 10 * CLK_DIV; c++) begin
      check($sformatf("tx byte %02h bit %0d", b, c / CLK_DIV), 32'(uart_tx), 32'(bits[c / CLK_DIV]));
      check($sformatf("busy byte %02h", b), 32'(busy), 32'd1);
      tick();
    end
  endtask

  task automatic check_frame(input logic [15:0] w, input int skip);
    check_byte(HEADER, skip);
    check_byte(w[15:8], 0);
    check_byte(w[7:0], 0);
`ifdef SAMPLE_UART_TX_CHECKSUM_EN
    check_byte(HEADER ^ w[15:8] ^ w[7:0], 0);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    check("reset uart_tx", 32'(uart_tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle uart_tx", 32'(uart_tx), 32'd1);
    end

    // Single frame 16'h1234 (checksum byte 0x83 when enabled)
    sample_in    = 16'h1234;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("single level after write", 32'(fifo_level), 32'd1);
    check("single busy after write", 32'(busy), 32'd1);
    tick();
    check("single level after pop", 32'(fifo_level), 32'd0);
    check("single tx before start", 32'(uart_tx), 32'd1);
    tick();
    check_frame(16'h1234, 0);
    check("single busy after frame", 32'(busy), 32'd0);
    check("single tx after frame", 32'(uart_tx), 32'd1);

    // Back-to-back frames
    sample_in    = 16'h0001;
    sample_valid = 1'b1;
    tick();
    check("b2b level 1st", 32'(fifo_level), 32'd1);
    sample_in = 16'hFFFE;
    tick();
    sample_valid = 1'b0;
    check("b2b level 2nd", 32'(fifo_level), 32'd1);
    tick();
    check_frame(16'h0001, 0);
    check("b2b level 3rd", 32'(fifo_level), 32'd0);
    check_frame(16'hFFFE, 0);
    check("b2b busy after", 32'(busy), 32'd0);
    check("b2b tx after", 32'(uart_tx), 32'd1);

    // Overflow: six strobes, sixth dropped
    for (int k = 0; k < 6; k++) begin
      logic [2:0] exp_lvl [6];
      exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      sample_in    = 16'(k);
      sample_valid = 1'b1;
      tick();
      check($sformatf("ovf level %0d", k), 32'(fifo_level), 32'(exp_lvl[k]));
    end
    sample_valid = 1'b0;
    check("ovf flag set", 32'(overflow), 32'd1);
    check_frame(16'h0000, 3);
    for (int k = 1; k < 5; k++) check_frame(16'(k), 0);
    check("ovf flag sticky", 32'(overflow), 32'd1);
    check("ovf busy after", 32'(busy), 32'd0);

    // Full FIFO with push on the exact pop cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("full rst overflow", 32'(overflow), 32'd0);
    check("full rst level", 32'(fifo_level), 32'd0);
    for (int k = 0; k < 5; k++) begin
      sample_in    = 16'h0010 + 16'(k);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("full level", 32'(fifo_level), 32'd4);
    repeat (FRAME_CYC - 3) tick();
    check("full level before pop", 32'(fifo_level), 32'd4);
    sample_in    = 16'h0015;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("full push+pop level", 32'(fifo_level), 32'd4);
    check("full push+pop overflow", 32'(overflow), 32'd0);
    for (int k = 1; k < 6; k++) check_frame(16'h0010 + 16'(k), 0);
    check("full overflow after", 32'(overflow), 32'd0);
    check("full busy after", 32'(busy), 32'd0);

    // Reset in the middle of the MSB byte
    sample_in    = 16'hBEEF;
    sample_valid = 1'b1;
    tick();
    sample_in = 16'h5555;
    tick();
    sample_valid = 1'b0;
    tick();
    check_byte(HEADER, 0);
    repeat (20) tick();
    check("midrst level before", 32'(fifo_level), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst uart_tx", 32'(uart_tx), 32'd1);
    check("midrst level", 32'(fifo_level), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst quiet tx", 32'(uart_tx), 32'd1);
      check("midrst quiet busy", 32'(busy), 32'd0);
    end
    sample_in    = 16'h0F0F;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    check("midrst tx before start", 32'(uart_tx), 32'd1);
    tick();
    check_frame(16'h0F0F, 0);
    check("midrst busy after", 32'(busy), 32'd0);
    check("midrst tx after", 32'(uart_tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_uart_tx.md
# sample_uart_tx

Streams 16-bit receiver samples (the `result_out` / `signal_out` words from `top_design_wrapper`) to the host over an 8N1 UART line. Samples are accepted on a strobe, buffered in a small FIFO, framed as header + MSB + LSB bytes, and serialized LSB-first. It is the host-facing transmit end of the sample path, and the counterpart to the host-side frame receiver.

## Interface
Parameters:
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, 16: sample FIFO entries. Must be a power of two, ≥ 2.
- `HEADER`, 8'hA5: frame sync byte.

Ports:
- `clk`, in, 1: sole clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sample_in`, in, 16: sample word.
- `sample_valid`, in, 1: write strobe. `sample_in` is captured on any cycle where this is high.
- `uart_tx`, out, 1: serial line. Idle is high.
- `busy`, out, 1: high while a frame is being shifted or the FIFO is non-empty.
- `overflow`, out, 1: sticky. Set when a sample is dropped because the FIFO is full.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO write:**
  - If `sample_valid` is high and the FIFO is not full, the sample is written.
  - If the FIFO is full, the sample is dropped and `overflow` is set. `overflow` clears only on `rst`.
  - A write and a pop in the same cycle are both performed, even when the FIFO is full; the write is accepted, so `overflow` is not set.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked with a separate counter.
- **Frame sequencer states:** IDLE → LOAD → HDR → MSB → LSB → (CHK) → IDLE.
  - IDLE: if the FIFO is non-empty, pop one word into the frame register and go to LOAD.
  - LOAD: hand the byte `HEADER` to the bit engine.
  - HDR, MSB, LSB: each state waits for the bit engine's done pulse. It then loads the next byte: `sample[15:8]`, then `sample[7:0]`.
  - After LSB completes: if the FIFO is non-empty, pop the next word immediately. There is no idle gap; the next frame's start bit directly follows the previous stop bit. Otherwise return to IDLE.
- **Bit engine:**
  - 10-bit shift: start bit 0, data bits D0..D7, stop bit 1.
  - Each bit is held for exactly `CLK_DIV` cycles, timed by a down-counter.
  - The bit engine asserts done in the last cycle of the stop bit.
- **`busy`:** high when the sequencer is not IDLE or `fifo_level != 0`.
- **Reset:** reset is honoured mid-frame. On the reset edge:
  - The FIFO is emptied.
  - The sequencer returns to IDLE.
  - `uart_tx` goes high.
  - Any partial frame is abandoned.

## Timing
- **Reset values:**
  - `uart_tx` = 1, `busy` = 0, `overflow` = 0, `fifo_level` = 0.
  - All counters and pointers = 0.
- **Latency:** with the FIFO empty and the sequencer IDLE, a sample strobed at edge E0 appears as follows:
  - `fifo_level` = 1 after E0.
  - Popped at E1.
  - `uart_tx` driven low (start bit) after E2.
  - Three-cycle latency, valid→start bit.
- **Frame length:**
  - 30·`CLK_DIV` cycles without the checksum.
  - 40·`CLK_DIV` cycles with the checksum.
- **Throughput:** back-to-back frames are gapless.
- **`fifo_level`:** updated on the edge following a write or pop; registered, never combinational.
- **`uart_tx`:** driven from a flop; no glitches.

## Configuration
- Macro: `SAMPLE_UART_TX_CHECKSUM_EN`.
- **Defined:** a fourth byte (CHK) is sent after LSB, where CHK = `HEADER ^ MSB ^ LSB`. Frame length is 40·`CLK_DIV` cycles.
- **Undefined:** the CHK state and its logic are absent. Frame length is 30·`CLK_DIV` cycles.

## Test plan
All scenarios use `CLK_DIV` = 4 and `FIFO_DEPTH` = 4.
- **Reset:** hold `rst` for 3 cycles, then release -> `uart_tx` = 1, `busy` = 0, `overflow` = 0, `fifo_level` = 0, and `uart_tx` stays at 1 for 100 cycles.
- **Single frame:** one strobe of 16'h1234 -> start bit after 3 cycles, then serial bytes A5, 12, 34 (LSB first, 4 cycles per bit). `busy` drops 120 cycles after the start bit. With the macro defined, byte 0x83 follows.
- **Back-to-back frames:** strobe 16'h0001, then 16'hFFFE on the next cycle -> two frames with no idle gap between the stop bit and the next start bit. `fifo_level` sequence is 1, 1, 0 around the pops.
- **Overflow:** 6 strobes on consecutive cycles (0x0000–0x0005) -> first word popped, four buffered, sixth dropped. `overflow` = 1 and stays set. Frames carry 0000, 0001, 0002, 0003, 0004.
- **Full FIFO, simultaneous push and pop:** write on the exact cycle of a pop -> write accepted, `overflow` remains 0.
- **Reset mid-frame:** assert `rst` in the middle of the MSB byte -> `uart_tx` = 1 the next cycle, `fifo_level` = 0. A new strobe afterwards produces a clean, complete frame.
